// File: rtl/shift_pipe_pkg.sv
// shift_pipe_pkg: shared opcode encodings and default widths for the
// shift/rotate execution unit.
//   OP_ROL / OP_SLL / OP_ROR / OP_SRL : 2-bit operation select values
//   N_DEF / C_DEF / T_DEF             : default data, count and tag widths
package shift_pipe_pkg;

    localparam int N_DEF = 16;  // data width (power of two)
    localparam int C_DEF = 4;   // count width, log2(N_DEF)
    localparam int T_DEF = 3;   // destination tag width

    // op[1] selects the right-moving family, op[0] selects shift (vs rotate)
    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

endpackage

// File: rtl/shift_pipe_shift_core.sv
// shift_core: purely combinational shift/rotate datapath.
//   data   [N-1:0] operand
//   cnt    [C-1:0] shift/rotate amount, 0..N-1
//   op     [1:0]   ROL / SLL / ROR / SRL
//   result [N-1:0] shifted/rotated operand
// A single left rotator serves all four ops: right-moving ops rotate left by
// the two's-complement negated count, then shifts mask off the vacated bits.
module shift_core
    import shift_pipe_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int C = C_DEF
) (
    input  logic [N-1:0] data,
    input  logic [C-1:0] cnt,
    input  logic [1:0]   op,
    output logic [N-1:0] result
);

    localparam logic [N-1:0] ONES = '1;

    logic [C-1:0]   lcnt;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;

    always_comb begin
        // (N - cnt) mod N falls out of C-bit negation; cnt=0 stays 0
        lcnt   = op[1] ? (~cnt + C'(1)) : cnt;
        // upper half of the doubled operand shifted left is the left rotation
        dbl    = {data, data} << lcnt;
        rot    = dbl[2*N-1:N];
        result = rot;
        case (op)
            OP_SLL:  result = rot & (ONES << cnt);
            OP_SRL:  result = rot & (ONES >> cnt);
            default: result = rot;
        endcase
    end

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: two-stage pipelined shift/rotate unit with valid/ready
// handshakes on both sides and a flush that kills everything in flight.
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid/in_ready        upstream handshake
//   in_data/in_cnt/in_op/in_tag  operand, amount, op select, destination tag
//   flush                    drop both stages (and any same-cycle input)
//   out_valid/out_ready      downstream handshake
//   out_data/out_tag/out_zero    result, its tag, result==0 flag
// Stage 1 registers the request; shift_core sits between stage 1 and
// stage 2; out_* come straight from the stage-2 registers.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int C = C_DEF,
    parameter int T = T_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [C-1:0] in_cnt,
    input  logic [1:0]   in_op,
    input  logic [T-1:0] in_tag,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [T-1:0] out_tag,
    output logic         out_zero
);

    // stage 1
    logic         s1_valid_q, s1_valid_d;
    logic [N-1:0] s1_data_q,  s1_data_d;
    logic [C-1:0] s1_cnt_q,   s1_cnt_d;
    logic [1:0]   s1_op_q,    s1_op_d;
    logic [T-1:0] s1_tag_q,   s1_tag_d;
    // stage 2
    logic         s2_valid_q, s2_valid_d;
    logic [N-1:0] s2_data_q,  s2_data_d;
    logic [T-1:0] s2_tag_q,   s2_tag_d;
    logic         s2_zero_q,  s2_zero_d;

    logic         adv1, adv2;
    logic [N-1:0] core_result;

    shift_core #(.N(N), .C(C)) u_core (
        .data   (s1_data_q),
        .cnt    (s1_cnt_q),
        .op     (s1_op_q),
        .result (core_result)
    );

    // A stage may load when it is empty or its occupant moves on this edge.
    // Flush is deliberately left out of the advance terms so in_ready never
    // depends on it; flush only clears the valid bits.
    always_comb begin
        adv2 = !s2_valid_q || out_ready;
        adv1 = !s1_valid_q || adv2;
    end

    assign in_ready = adv1;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_cnt_d   = s1_cnt_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;
        s2_zero_d  = s2_zero_q;

        if (adv1) begin
            s1_valid_d = in_valid;
            s1_data_d  = in_data;
            s1_cnt_d   = in_cnt;
            s1_op_d    = in_op;
            s1_tag_d   = in_tag;
        end
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = core_result;
            s2_tag_d   = s1_tag_q;
            s2_zero_d  = (core_result == '0);
        end
        // stale payload is harmless once the valid bits are cleared
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_cnt_q   <= '0;
            s1_op_q    <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
            s2_zero_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_op_q    <= s1_op_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_tag_q   <= s2_tag_d;
            s2_zero_q  <= s2_zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;
    assign out_zero  = s2_zero_q;

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed scenarios plus a randomized run checked against a
// bit-level reference of the shift/rotate rules and an in-flight queue.
module tb_shift_pipe;

    localparam int N = 16;
    localparam int C = 4;
    localparam int T = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic [C-1:0] in_cnt;
    logic [1:0]   in_op;
    logic [T-1:0] in_tag;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [T-1:0] out_tag;
    logic         out_zero;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    shift_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference: each result bit taken straight from the operation's definition.
    function automatic logic [N-1:0] ref_shift(logic [N-1:0] d, int n, logic [1:0] op);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            case (op)
                2'b00: r[(i + n) % N] = d[i];
                2'b01: if (i >= n) r[i] = d[i - n];
                2'b10: r[i] = d[(i + n) % N];
                default: if (i + n < N) r[i] = d[i + n];
            endcase
        end
        return r;
    endfunction

    task automatic drive(input logic [N-1:0] d, input int n, input logic [1:0] op, input int tag);
        in_valid = 1'b1;
        in_data  = d;
        in_cnt   = C'(n);
        in_op    = op;
        in_tag   = T'(tag);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_data = '0; in_cnt = '0; in_op = '0; in_tag = '0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got %h want 0000", out_data); end
        total++; if (out_tag !== '0) begin bad++; $display("FAIL reset_tag got %h want 0", out_tag); end
        total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL reset_zero got %b want 0", out_zero); end
        @(negedge clk); rst = 1'b0; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [N-1:0] dv [4] = '{16'h8001, 16'h8001, 16'h0001, 16'h8000};
        int           cv [4] = '{1, 4, 1, 15};
        logic [1:0]   ov [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [N-1:0] ev [4] = '{16'h0003, 16'h0010, 16'h8000, 16'h0001};
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (cyc < 4) drive(dv[cyc], cv[cyc], ov[cyc], cyc);
            else in_valid = 1'b0;
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready cyc%0d got %b want 1", cyc, in_ready); end
            @(posedge clk); #1;
            total++;
            if (cyc == 0) begin
                if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_latency got valid %b want 0", out_valid); end
            end else if (out_valid !== 1'b1 || out_data !== ev[cyc-1] || out_tag !== T'(cyc-1) || out_zero !== 1'b0) begin
                bad++;
                $display("FAIL basic_op%0d got v=%b d=%h t=%0d z=%b want v=1 d=%h t=%0d z=0",
                         cyc-1, out_valid, out_data, out_tag, out_zero, ev[cyc-1], cyc-1);
            end
        end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got valid %b want 0", out_valid); end
    endtask

    task automatic test_boundary;
        logic [N-1:0] dv [6] = '{16'h0001, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hFFFF};
        int           cv [6] = '{1, 0, 0, 0, 0, 15};
        logic [1:0]   ov [6] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
        logic [N-1:0] ev [6] = '{16'h0000, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h8000};
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 7; cyc++) begin
            if (cyc < 6) drive(dv[cyc], cv[cyc], ov[cyc], cyc);
            else in_valid = 1'b0;
            @(posedge clk); #1;
            if (cyc > 0) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== ev[cyc-1] || out_tag !== T'(cyc-1) ||
                    out_zero !== (ev[cyc-1] == '0)) begin
                    bad++;
                    $display("FAIL boundary_op%0d got v=%b d=%h t=%0d z=%b want v=1 d=%h t=%0d z=%b",
                             cyc-1, out_valid, out_data, out_tag, out_zero, ev[cyc-1], cyc-1, ev[cyc-1] == '0);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(16'h1234, 4, 2'b00, 1);
        @(posedge clk); #1;
        drive(16'hF000, 8, 2'b11, 2);
        @(posedge clk); #1;
        drive(16'h00FF, 4, 2'b10, 3);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
        total++; if (out_valid !== 1'b1 || out_data !== 16'h2341 || out_tag !== 3'd1) begin
            bad++; $display("FAIL bp_first got v=%b d=%h t=%0d want v=1 d=2341 t=1", out_valid, out_data, out_tag); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_data !== 16'h2341 || out_tag !== 3'd1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_stable got v=%b d=%h t=%0d rdy=%b want v=1 d=2341 t=1 rdy=0",
                            out_valid, out_data, out_tag, in_ready); end
        out_ready = 1'b1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 16'h00F0 || out_tag !== 3'd2) begin
            bad++; $display("FAIL bp_second got v=%b d=%h t=%0d want v=1 d=00f0 t=2", out_valid, out_data, out_tag); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_data !== 16'hF00F || out_tag !== 3'd3) begin
            bad++; $display("FAIL bp_third got v=%b d=%h t=%0d want v=1 d=f00f t=3", out_valid, out_data, out_tag); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got valid %b want 0", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(16'h0F0F, 2, 2'b01, 1);
        @(posedge clk); #1;
        drive(16'h1111, 3, 2'b00, 2);
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_prefill got valid %b want 1", out_valid); end
        drive(16'h2222, 1, 2'b10, 3);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_killed_%0d got valid %b want 0", k, out_valid); end
            @(posedge clk); #1;
        end
        drive(16'hABCD, 4, 2'b11, 5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_next_early got valid %b want 0", out_valid); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_data !== 16'h0ABC || out_tag !== 3'd5) begin
            bad++; $display("FAIL flush_next got v=%b d=%h t=%0d want v=1 d=0abc t=5", out_valid, out_data, out_tag); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        drive(16'h00F0, 4, 2'b00, 1);
        @(posedge clk); #1;
        drive(16'h00F0, 4, 2'b00, 2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 16'h0F00) begin
            bad++; $display("FAIL rstmid_prefill got v=%b d=%h want v=1 d=0f00", out_valid, out_data); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== '0 || out_zero !== 1'b0 || out_tag !== '0) begin
            bad++; $display("FAIL rstmid_clear got v=%b d=%h z=%b t=%0d want all 0", out_valid, out_data, out_zero, out_tag); end
        @(posedge clk);
        @(negedge clk); rst = 1'b0; out_ready = 1'b1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        drive(16'h0001, 15, 2'b01, 6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_early got valid %b want 0", out_valid); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_data !== 16'h8000 || out_tag !== 3'd6) begin
            bad++; $display("FAIL rstmid_first got v=%b d=%h t=%0d want v=1 d=8000 t=6", out_valid, out_data, out_tag); end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [N-1:0] d;
        logic [T-1:0] t;
        int           acc;
    } exp_t;

    task automatic test_random;
        exp_t q[$];
        exp_t e;
        logic pend, exp_ir, exp_ov, hs_in, hs_out, fl;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pend = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!pend) begin
                in_valid = ($urandom % 4) != 0;
                in_data  = N'($urandom);
                in_cnt   = C'($urandom);
                in_op    = 2'($urandom);
                in_tag   = T'($urandom);
            end
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 24) == 0;
            #1;
            // full only when two ops are in flight and nothing drains
            exp_ir = !(q.size() == 2 && !out_ready);
            exp_ov = q.size() > 0 && q[0].acc < edge_cnt;
            total++; if (in_ready !== exp_ir) begin bad++; $display("FAIL rand_in_ready cyc%0d got %b want %b", cyc, in_ready, exp_ir); end
            total++; if (out_valid !== exp_ov) begin bad++; $display("FAIL rand_out_valid cyc%0d got %b want %b", cyc, out_valid, exp_ov); end
            if (exp_ov) begin
                total++;
                if (out_data !== q[0].d || out_tag !== q[0].t || out_zero !== (q[0].d == '0)) begin
                    bad++;
                    $display("FAIL rand_result cyc%0d got d=%h t=%0d z=%b want d=%h t=%0d z=%b",
                             cyc, out_data, out_tag, out_zero, q[0].d, q[0].t, q[0].d == '0);
                end
            end
            fl     = flush;
            hs_in  = in_valid && exp_ir && !fl;
            hs_out = exp_ov && out_ready && !fl;
            pend   = in_valid && !exp_ir;
            e.d = ref_shift(in_data, int'(in_cnt), in_op);
            e.t = in_tag;
            @(posedge clk); #1;
            if (fl) q.delete();
            else begin
                if (hs_out) void'(q.pop_front());
                if (hs_in) begin e.acc = edge_cnt; q.push_back(e); end
            end
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
